// File: rtl/play_if.sv
// Playback bus bundle: SDRAM read/finished handshake plus the DAC valid/ready sample stream.
interface play_if #(
    parameter int unsigned ADDR_W = 23,
    parameter int unsigned DATA_W = 32
);
    logic              play_read;
    logic [ADDR_W-1:0] play_addr;
    logic [DATA_W-1:0] play_readdata;
    logic              play_sdram_finished;
    logic [DATA_W-1:0] play_audio_data;
    logic              play_audio_valid;
    logic              play_audio_ready;

    modport master (
        output play_read, play_addr, play_audio_data, play_audio_valid,
        input  play_readdata, play_sdram_finished, play_audio_ready
    );

    modport slave (
        input  play_read, play_addr, play_audio_data, play_audio_valid,
        output play_readdata, play_sdram_finished, play_audio_ready
    );
endinterface

// File: rtl/play_core.sv
// Playback engine: fetches sample words from SDRAM into a prefetch FIFO and
// streams them to the DAC path, with pause, stop and loop control.
module play_core #(
    parameter int unsigned ADDR_W     = 23,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              play_start,
    input  logic [ADDR_W-1:0] play_start_addr,
    input  logic [ADDR_W-1:0] play_end_addr,
    input  logic              play_loop,
    input  logic              play_pause,
    input  logic              play_stop,
    output logic              play_done,
    play_if.master            bus
);
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_WAIT_SPACE, S_DRAIN, S_ABORT, S_DONE
    } state_t;

    state_t state, state_n;

    logic              start_q;
    logic [ADDR_W-1:0] start_addr_q, end_addr_q, addr_q, addr_n;
    logic              loop_q, latch;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr, rd_ptr_n;
    logic [CNT_W-1:0]  count, count_pp, count_n;
    logic              start_edge, push, pop, flush;
    logic              read_q, valid_q, read_n, valid_n, done_n;
    logic [DATA_W-1:0] data_q, head_n;

    assign start_edge = play_start & ~start_q;
    assign pop        = valid_q & bus.play_audio_ready;
    assign push       = (state == S_FETCH) & bus.play_sdram_finished & ~play_stop;
    assign flush      = (state == S_DONE);
    assign count_pp   = count + CNT_W'(push) - CNT_W'(pop);
    assign count_n    = flush ? '0 : count_pp;
    assign rd_ptr_n   = flush ? '0 : rd_ptr + PTR_W'(pop);

    // Next head word: bypass the incoming read data when it lands in an empty FIFO
    assign head_n = (push && (count - CNT_W'(pop)) == '0) ? bus.play_readdata : mem[rd_ptr_n];

    assign bus.play_read        = read_q;
    assign bus.play_addr        = addr_q;
    assign bus.play_audio_valid = valid_q;
    assign bus.play_audio_data  = data_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= S_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        addr_n  = addr_q;
        latch   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_edge && !play_stop) begin
                    latch   = 1'b1;
                    addr_n  = play_start_addr;
                    state_n = (play_end_addr < play_start_addr) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                // A stop coinciding with finished has nothing left in flight
                if (play_stop) begin
                    state_n = bus.play_sdram_finished ? S_DONE : S_ABORT;
                end else if (bus.play_sdram_finished) begin
                    if (addr_q == end_addr_q && !loop_q) begin
                        state_n = S_DRAIN;
                    end else begin
                        addr_n  = (addr_q == end_addr_q) ? start_addr_q : addr_q + ADDR_W'(1);
                        state_n = (count_pp < DEPTH_C) ? S_FETCH : S_WAIT_SPACE;
                    end
                end
            end
            S_WAIT_SPACE: begin
                if (play_stop)                state_n = S_DONE;
                else if (count_pp < DEPTH_C)  state_n = S_FETCH;
            end
            S_DRAIN: begin
                if (play_stop || count_pp == '0) state_n = S_DONE;
            end
            S_ABORT: begin
                if (bus.play_sdram_finished) state_n = S_DONE;
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase

        read_n  = (state_n == S_FETCH) || (state_n == S_ABORT);
        done_n  = (state_n == S_DONE);
        valid_n = (state_n == S_FETCH || state_n == S_WAIT_SPACE || state_n == S_DRAIN)
                  && (count_n != '0) && !play_pause;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            start_q      <= 1'b0;
            start_addr_q <= '0;
            end_addr_q   <= '0;
            loop_q       <= 1'b0;
            addr_q       <= '0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            read_q       <= 1'b0;
            valid_q      <= 1'b0;
            data_q       <= '0;
            play_done    <= 1'b0;
        end else begin
            start_q <= play_start;
            if (latch) begin
                start_addr_q <= play_start_addr;
                end_addr_q   <= play_end_addr;
                loop_q       <= play_loop;
            end
            addr_q    <= addr_n;
            rd_ptr    <= rd_ptr_n;
            wr_ptr    <= flush ? '0 : wr_ptr + PTR_W'(push);
            count     <= count_n;
            read_q    <= read_n;
            valid_q   <= valid_n;
            data_q    <= head_n;
            play_done <= done_n;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) mem[i] <= '0;
        end else if (push) begin
            mem[wr_ptr] <= bus.play_readdata;
        end
    end
endmodule

// File: tb/tb_play_core.sv
// Randomized bench for play_core: SDRAM responder, DAC sink and an address-sequence
// reference model built from the playback rules.
module tb_play_core;
    localparam int unsigned AW    = 23;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 4;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          play_start = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [AW-1:0] end_addr = '0;
    logic          loop_in = 1'b0;
    logic          play_pause = 1'b0;
    logic          play_stop = 1'b0;
    logic          play_done;

    play_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    play_core #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .play_start      (play_start),
        .play_start_addr (start_addr),
        .play_end_addr   (end_addr),
        .play_loop       (loop_in),
        .play_pause      (play_pause),
        .play_stop       (play_stop),
        .play_done       (play_done),
        .bus             (bus)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: test parameters, owned by the stimulus process
    logic [AW-1:0] m_start = '0, m_end = '0;
    bit            m_loop = 1'b0;
    int            m_total = 0;
    int            gen = 0;

    function automatic logic [DW-1:0] word_at(input logic [AW-1:0] a);
        return (DW'(a) * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    function automatic logic [AW-1:0] adv(input logic [AW-1:0] a);
        return (m_loop && a == m_end) ? m_start : a + AW'(1);
    endfunction

    // SDRAM responder: one read at a time, finished after a (random) latency
    int            lat_fixed = 2;
    bit            lat_rand = 1'b0;
    int            cnt = 0, reads = 0, sd_gen = 0;
    bit            busy = 1'b0;
    logic [AW-1:0] cur = '0, exp_rd = '0;

    always @(negedge i_clk) begin
        if (gen != sd_gen) begin
            sd_gen = gen;
            reads  = 0;
            exp_rd = m_start;
        end
        bus.play_sdram_finished = 1'b0;
        if (i_rst || !bus.play_read) begin
            busy = 1'b0;
            bus.play_readdata = '0;
        end else begin
            if (!busy) begin
                busy = 1'b1;
                cur  = bus.play_addr;
                cnt  = lat_rand ? int'($urandom_range(3, 0)) : lat_fixed;
                reads++;
                check("rd_addr", cur, exp_rd);
                if (!m_loop) check("rd_in_range", reads <= m_total, 1);
                exp_rd = adv(exp_rd);
            end else begin
                check("rd_addr_stable", bus.play_addr, cur);
            end
            if (cnt == 0) begin
                bus.play_sdram_finished = 1'b1;
                bus.play_readdata       = word_at(cur);
                busy = 1'b0;
            end else begin
                cnt--;
            end
        end
    end

    bit rdy_rand = 1'b0;
    bit rdy_lvl  = 1'b1;
    always @(negedge i_clk) bus.play_audio_ready = rdy_rand ? 1'($urandom_range(1, 0)) : rdy_lvl;

    // DAC sink: every accepted word must be the next one of the address sequence
    int            words = 0, done_cnt = 0, mon_gen = 0;
    logic [AW-1:0] exp_out = '0;

    always @(negedge i_clk) begin
        #1;
        if (gen != mon_gen) begin
            mon_gen  = gen;
            words    = 0;
            done_cnt = 0;
            exp_out  = m_start;
        end
        if (!i_rst) begin
            if (bus.play_audio_valid && bus.play_audio_ready) begin
                words++;
                check("word", bus.play_audio_data, word_at(exp_out));
                exp_out = adv(exp_out);
            end
            if (play_done) done_cnt++;
        end
    end

    task automatic step();
        @(negedge i_clk);
        #2;
    endtask

    task automatic new_test(input logic [AW-1:0] s, input logic [AW-1:0] e, input bit l);
        m_start = s;
        m_end   = e;
        m_loop  = l;
        m_total = (e >= s) ? int'(e) - int'(s) + 1 : 0;
        gen++;
        step();
    endtask

    task automatic start_play(input logic [AW-1:0] s, input logic [AW-1:0] e, input bit l);
        new_test(s, e, l);
        start_addr = s;
        end_addr   = e;
        loop_in    = l;
        play_start = 1'b1;
        step();
        play_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        for (int i = 0; i < budget && done_cnt == 0; i++) step();
        step();
        step();
        check(tag, done_cnt, 1);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        repeat (3) step();
        check("rst_read",  bus.play_read, 0);
        check("rst_addr",  bus.play_addr, 0);
        check("rst_done",  play_done, 0);
        check("rst_valid", bus.play_audio_valid, 0);
        check("rst_data",  bus.play_audio_data, 0);
        i_rst = 1'b0;
        repeat (2) step();

        // Basic non-looping playback, fixed latency
        lat_fixed = 2; lat_rand = 1'b0; rdy_rand = 1'b0; rdy_lvl = 1'b1;
        start_play(23'h100, 23'h103, 1'b0);
        check("t1_latency", bus.play_read, 1);
        wait_done("t1_done", 100);
        check("t1_reads", reads, 4);
        check("t1_words", words, 4);
        check("t1_idle_read", bus.play_read, 0);
        check("t1_idle_valid", bus.play_audio_valid, 0);

        // Back-pressure fills the FIFO, then random ready drains it
        lat_rand = 1'b1; rdy_lvl = 1'b0;
        start_play(23'h100, 23'h10F, 1'b0);
        repeat (40) step();
        check("t2_reads_full", reads, DEPTH);
        check("t2_read_low", bus.play_read, 0);
        check("t2_valid", bus.play_audio_valid, 1);
        check("t2_head", bus.play_audio_data, word_at(23'h100));
        rdy_rand = 1'b1;
        wait_done("t2_done", 400);
        check("t2_words", words, 16);
        check("t2_reads", reads, 16);
        rdy_rand = 1'b0; rdy_lvl = 1'b1;

        // Loop until stopped
        start_play(23'h010, 23'h011, 1'b1);
        repeat (40) step();
        check("t3_no_done", done_cnt, 0);
        check("t3_reads", reads >= 8, 1);
        check("t3_words", words >= 6, 1);
        play_stop = 1'b1;
        wait_done("t3_done", 8);
        play_stop = 1'b0;

        // Stop while a slow read is in flight
        lat_rand = 1'b0; lat_fixed = 5;
        start_play(23'h200, 23'h2FF, 1'b0);
        for (int i = 0; i < 200 && reads < 3; i++) step();
        check("t4_third_read", reads, 3);
        play_stop = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t4_read_held", bus.play_read, 1);
            check("t4_no_valid", bus.play_audio_valid, 0);
            check("t4_no_done", play_done, 0);
        end
        step();
        check("t4_done", play_done, 1);
        check("t4_read_drop", bus.play_read, 0);
        step();
        play_stop = 1'b0;
        repeat (3) step();
        check("t4_words", words, 2);
        check("t4_done_once", done_cnt, 1);

        // Pause mid-stream
        lat_rand = 1'b1;
        start_play(23'h300, 23'h31F, 1'b0);
        repeat (8) step();
        play_pause = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check("t5_paused", bus.play_audio_valid, 0);
        end
        play_pause = 1'b0;
        step();
        check("t5_resume", bus.play_audio_valid, 1);
        wait_done("t5_done", 400);
        check("t5_words", words, 32);
        check("t5_reads", reads, 32);

        // End at the top of the address space: no wrap
        start_play(23'h7FFFFE, 23'h7FFFFF, 1'b0);
        wait_done("t6_done", 100);
        check("t6_reads", reads, 2);
        check("t6_words", words, 2);

        // End below start: immediate done, no reads
        start_play(23'h000005, 23'h000004, 1'b0);
        wait_done("t7_done", 2);
        check("t7_reads", reads, 0);

        // Start and stop together in IDLE: nothing happens
        new_test(23'h000040, 23'h000050, 1'b0);
        start_addr = 23'h40; end_addr = 23'h50; loop_in = 1'b0;
        play_stop  = 1'b1;
        play_start = 1'b1;
        repeat (10) step();
        check("t8_read", bus.play_read, 0);
        check("t8_reads", reads, 0);
        check("t8_done", done_cnt, 0);
        play_stop = 1'b0;
        repeat (3) step();
        check("t8_held_start", reads, 0);
        play_start = 1'b0;
        repeat (2) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
